button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 88 ++++++++
 tb/tb_button_debounce.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Four-bit push-button debouncer: two-flop synchronizer, then a symmetric per-bit stable-count filter.
// Optional press pulses are built only when BUTTON_PRESS_PULSE_EN is defined; otherwise press is tied low.
module button_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  output logic [3:0] b,
  output logic [3:0] press,
  output logic       stable
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0]         db_q, db_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic               stable_q, stable_d;

  // Next-state: synchronizer shift plus the per-bit count/commit filter.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_d     = db_q;
    cnt_d    = cnt_q;
    stable_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
      // stable is registered from the counters' next values so it lines up with them.
      stable_d = stable_d & (cnt_d[i] == CNT_ZERO);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      db_q     <= 4'b0000;
      cnt_q    <= {4{CNT_ZERO}};
      stable_q <= 1'b1;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

`ifdef BUTTON_PRESS_PULSE_EN
  logic [3:0] press_q, press_d;

  // Rising edge of the debounced level, registered so it coincides with b going high.
  always_comb begin
    press_d = db_d & ~db_q;
  end

  // Press pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_q <= 4'b0000;
    end else begin
      press_q <= press_d;
    end
  end

  assign press = press_q;
`else
  assign press = 4'b0000;
`endif

  assign b      = db_q;
  assign stable = stable_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (DB_CYCLES=4): windowed reference model plus directed literal checks.
module tb_button_debounce;

  localparam int DB = 4;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] b;
  logic [3:0] press;
  logic       stable;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_debounce #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .b       (b),
    .press   (press),
    .stable  (stable)
  );

  // Reference model: hist[k] is btn_raw sampled at the k-th edge after reset (hist[0] is padding).
  // A bit flips at edge n when the last DB synchronized samples (raw from edges n-1-DB .. n-2) all differ from it.
  logic [3:0] hist [$];
  int         n = 0;
  int         last_flip [4] = '{0, 0, 0, 0};
  logic [3:0] m_b      = 4'b0000;
  logic [3:0] m_press  = 4'b0000;
  logic       m_stable = 1'b1;

  function automatic logic [3:0] hist_at(input int k);
    if (k < 1 || k >= hist.size()) return 4'b0000;
    return hist[k];
  endfunction

  function automatic logic [3:0] exp_press(input logic [3:0] rise);
`ifdef BUTTON_PRESS_PULSE_EN
    return rise;
`else
    return 4'b0000 & rise;
`endif
  endfunction

  function automatic logic [3:0] f_flip(input int nn, input logic [3:0] cur_b);
    logic [3:0] fl;
    logic [3:0] v;
    fl = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      fl[i] = (nn - 1 - DB) >= (last_flip[i] - 1);
      for (int k = nn - 1 - DB; k <= nn - 2; k++) begin
        v = hist_at(k);
        if (v[i] == cur_b[i]) fl[i] = 1'b0;
      end
    end
    return fl;
  endfunction

  function automatic logic f_stable(input int nn, input logic [3:0] cur_b, input logic [3:0] fl);
    logic [3:0] v;
    v = hist_at(nn - 2);
    for (int i = 0; i < 4; i++) begin
      if (!fl[i] && (v[i] != cur_b[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      hist.push_back(4'b0000);
      n        <= 0;
      m_b      <= 4'b0000;
      m_press  <= 4'b0000;
      m_stable <= 1'b1;
      for (int i = 0; i < 4; i++) last_flip[i] <= 0;
    end else begin
      hist.push_back(btn_raw);
      n        <= n + 1;
      m_b      <= m_b ^ f_flip(n + 1, m_b);
      m_press  <= exp_press(f_flip(n + 1, m_b) & ~m_b);
      m_stable <= f_stable(n + 1, m_b, f_flip(n + 1, m_b));
      for (int i = 0; i < 4; i++) begin
        if (f_flip(n + 1, m_b) != 4'b0000 && f_flip(n + 1, m_b) >> i & 4'b0001) last_flip[i] <= n + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_b", b, m_b);
    chk("model_press", press, m_press);
    chk("model_stable", {3'b000, stable}, {3'b000, m_stable});
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    edge1();
    edge1();
    reset = 1'b0;
  endtask

  logic [3:0] pat_v [7] = '{4'b0011, 4'b0111, 4'b0101, 4'b1101, 4'b0100, 4'b0000, 4'b1111};
  int         pat_h [7] = '{8, 3, 6, 2, 7, 9, 8};

  initial begin
    edge1();
    do_reset();
    chk("reset_b", b, 4'b0000);
    chk("reset_press", press, 4'b0000);
    chk("reset_stable", {3'b000, stable}, 4'b0001);

    // Single press: b rises on the 6th edge after the input change.
    btn_raw = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      edge1();
      if (k == 2) chk("t1_stable_e2", {3'b000, stable}, 4'b0001);
      if (k == 3) chk("t1_stable_e3", {3'b000, stable}, 4'b0000);
      if (k == 5) chk("t1_b_e5", b, 4'b0000);
      if (k == 6) begin
        chk("t1_b_e6", b, 4'b0001);
        chk("t1_stable_e6", {3'b000, stable}, 4'b0001);
        chk("t1_press_e6", press, exp_press(4'b0001));
      end
      if (k == 7) chk("t1_press_e7", press, 4'b0000);
    end

    // Release: same timing, no press pulse.
    edge1();
    edge1();
    btn_raw = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      edge1();
      if (k == 5) chk("rel_b_e5", b, 4'b0001);
      if (k == 6) begin
        chk("rel_b_e6", b, 4'b0000);
        chk("rel_press_e6", press, 4'b0000);
      end
    end

    // Bouncing bit 2 never debounces; a clean hold then does.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      btn_raw = ((c >> 1) & 1) != 0 ? 4'b0000 : 4'b0100;
      edge1();
      chk("bounce_b", b, 4'b0000);
    end
    btn_raw = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      edge1();
      if (k == 5) chk("bounce_hold_e5", b, 4'b0000);
      if (k == 6) chk("bounce_hold_e6", b, 4'b0100);
    end

    // Two bits changing together update together.
    do_reset();
    btn_raw = 4'b1001;
    for (int k = 1; k <= 7; k++) begin
      edge1();
      if (k == 5) chk("multi_b_e5", b, 4'b0000);
      if (k == 6) begin
        chk("multi_b_e6", b, 4'b1001);
        chk("multi_press_e6", press, exp_press(4'b1001));
      end
      if (k == 7) chk("multi_press_e7", press, 4'b0000);
    end

    // Reset mid-count discards progress; held button debounces afresh.
    do_reset();
    btn_raw = 4'b0010;
    edge1();
    edge1();
    edge1();
    reset = 1'b1;
    #1;
    chk("midrst_b", b, 4'b0000);
    chk("midrst_stable", {3'b000, stable}, 4'b0001);
    chk("midrst_press", press, 4'b0000);
    edge1();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      edge1();
      if (k == 5) chk("midrst_b_e5", b, 4'b0000);
      if (k == 6) begin
        chk("midrst_b_e6", b, 4'b0010);
        chk("midrst_press_e6", press, exp_press(4'b0010));
      end
    end

    // Mixed directed pattern, checked against the model only.
    do_reset();
    for (int p = 0; p < 7; p++) begin
      btn_raw = pat_v[p];
      for (int h = 0; h < pat_h[p]; h++) edge1();
    end
    edge1();
    edge1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
